// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for uart_lite.
// XLEN is the project-wide data-bus width.
package uart_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] RXDATA_OFF = 2'd1;
  localparam logic [1:0] STATUS_OFF = 2'd2;
  localparam logic [1:0] DIV_OFF    = 2'd3;

  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_DROP = 4;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Divisors below MIN_DIV are clamped so the bit timing stays meaningful.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 transmit engine: pops bytes from the TX FIFO and shifts them out LSB first.
// txd is registered one cycle behind the state so it never glitches.
module uart_tx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] div_i,
  input  logic        fifo_empty_i,
  input  logic [7:0]  fifo_data_i,
  output logic        pop_o,
  output logic        busy_o,
  output logic        txd_o
);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic [15:0] per_m1;
  logic        tick;

  // The period is sampled only when a bit starts, so DIV edits apply at the next boundary.
  assign per_m1 = bit_period(div_i) - 16'd1;
  assign tick   = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pop_o   = 1'b0;
    if (state_q != TX_IDLE) cnt_d = cnt_q - 16'd1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty_i) begin
          pop_o   = 1'b1;
          sh_d    = fifo_data_i;
          cnt_d   = per_m1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          cnt_d   = per_m1;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          cnt_d = per_m1;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty_i) begin
            pop_o   = 1'b1;
            sh_d    = fifo_data_i;
            cnt_d   = per_m1;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = sh_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= TX_IDLE;
      cnt_q   <= 16'd0;
      sh_q    <= 8'd0;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end

  assign busy_o = (state_q != TX_IDLE);
  assign txd_o  = txd_q;

endmodule

// File: rtl/uart_lite.sv
// Memory-mapped 8N1 UART slave: TX FIFO + shift engine, optional RX path, register file.
// Define UART_RX_EN to build the receiver; otherwise uart_rxd is ignored.
module uart_lite
  import uart_pkg::*;
#(
  parameter int          AW        = 16,
  parameter int          TXF_DEPTH = 4,
  parameter logic [15:0] DIV_RST   = 16'd434
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              uart_req,
  input  logic              uart_write,
  input  logic [XLEN/8-1:0] uart_wstrb,
  input  logic [AW-1:0]     uart_addr,
  input  logic [XLEN-1:0]   uart_wdata,
  output logic              uart_addr_ok,
  output logic              uart_data_ok,
  output logic [XLEN-1:0]   uart_rdata,
  output logic              uart_txd,
  input  logic              uart_rxd
);

  localparam int PW = $clog2(TXF_DEPTH);

  logic            acc, wr_acc, rd_acc;
  logic [1:0]      off;
  logic            data_ok_q;
  logic [XLEN-1:0] rdata_q, rd_val;
  logic [15:0]     div_q;
  logic            drop_q;
  logic            div_we, st_clr;
  logic            tx_busy;

  logic [7:0]      fifo_mem [TXF_DEPTH];
  logic [PW:0]     wp_q, rp_q;
  logic            fifo_empty, fifo_full, push_req, push, pop;

  logic            rx_valid, rx_ovr, rx_ferr;
  logic [7:0]      rx_byte;

  assign uart_addr_ok = 1'b1;
  assign acc    = uart_req & uart_addr_ok;
  assign wr_acc = acc & uart_write;
  assign rd_acc = acc & ~uart_write;
  assign off    = uart_addr[3:2];
  assign div_we = wr_acc && (off == DIV_OFF);
  assign st_clr = wr_acc && (off == STATUS_OFF) && uart_wstrb[0];

  // A full FIFO still accepts a push when the engine pops in the same cycle.
  assign fifo_empty = (wp_q == rp_q);
  assign fifo_full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign push_req   = wr_acc && (off == TXDATA_OFF) && uart_wstrb[0];
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp_q[PW-1:0]] <= uart_wdata[7:0];
  end

  uart_tx u_tx (
    .clk          (clk),
    .rst_b        (rst_b),
    .div_i        (div_q),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_mem[rp_q[PW-1:0]]),
    .pop_o        (pop),
    .busy_o       (tx_busy),
    .txd_o        (uart_txd)
  );

`ifdef UART_RX_EN
  logic        rx_s1_q, rx_s2_q;
  rx_state_e   rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_per;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_tick, rx_done, rx_pop, ovr_set;
  logic        rx_valid_q, rx_ovr_q, rx_ferr_q;

  assign rx_per  = bit_period(div_q);
  assign rx_tick = (rx_cnt_q == 16'd0);
  assign rx_pop  = rd_acc && (off == RXDATA_OFF) && rx_valid_q;
  assign ovr_set = rx_done && rx_valid_q && !rx_pop;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_sh_d  = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_done  = 1'b0;
    if (rx_st_q != RX_IDLE) rx_cnt_d = rx_cnt_q - 16'd1;
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d = (rx_per >> 1) - 16'd1;
          rx_st_d  = RX_START;
        end
      end
      RX_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (rx_tick) begin
          rx_cnt_d = rx_per - 16'd1;
          rx_bit_d = 3'd0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_d = rx_per - 16'd1;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_done = 1'b1;
          rx_st_d = RX_IDLE;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_sh_q    <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q  <= uart_rxd;
      rx_s2_q  <= rx_s1_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_sh_q  <= rx_sh_d;
      rx_bit_q <= rx_bit_d;
      if (rx_done && !ovr_set) begin
        rx_byte_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
        rx_valid_q <= 1'b0;
      end
      if (ovr_set) rx_ovr_q <= 1'b1;
      else if (st_clr && uart_wdata[ST_OVR]) rx_ovr_q <= 1'b0;
      if (rx_done && !rx_s2_q) rx_ferr_q <= 1'b1;
      else if (st_clr && uart_wdata[ST_FERR]) rx_ferr_q <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_ferr  = rx_ferr_q;
`else
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_valid   = 1'b0;
  assign rx_byte    = 8'd0;
  assign rx_ovr     = 1'b0;
  assign rx_ferr    = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      RXDATA_OFF: rd_val = XLEN'({~rx_valid, 23'd0, rx_byte});
      STATUS_OFF: rd_val = XLEN'({drop_q, rx_ferr, rx_ovr, tx_busy | ~fifo_empty, fifo_full});
      DIV_OFF:    rd_val = XLEN'(div_q);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      div_q     <= DIV_RST;
      drop_q    <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
    end else begin
      data_ok_q <= acc;
      rdata_q   <= rd_acc ? rd_val : '0;
      if (div_we && uart_wstrb[0]) div_q[7:0]  <= uart_wdata[7:0];
      if (div_we && uart_wstrb[1]) div_q[15:8] <= uart_wdata[15:8];
      if (push_req && !push) drop_q <= 1'b1;
      else if (st_clr && uart_wdata[ST_DROP]) drop_q <= 1'b0;
      if (push) wp_q <= wp_q + (PW+1)'(1);
      if (pop)  rp_q <= rp_q + (PW+1)'(1);
    end
  end

  assign uart_data_ok = data_ok_q;
  assign uart_rdata   = rdata_q;

  logic unused_bus;
  assign unused_bus = ^{uart_addr[AW-1:4], uart_addr[1:0],
                        uart_wdata[XLEN-1:16], uart_wstrb[XLEN/8-1:2]};

endmodule

// File: tb/tb_uart_lite.sv
// Directed bench for uart_lite: bus handshake, register map, TX framing, optional RX path.
// RX scenarios compile in when UART_RX_EN is defined, matching the DUT build.
module tb_uart_lite;

  logic        clk = 1'b0;
  logic        rst_b, req, write, addr_ok, data_ok, txd, rxd;
  logic [3:0]  wstrb;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [15:0] A_TX = 16'h0000;
  localparam logic [15:0] A_RX = 16'h0004;
  localparam logic [15:0] A_ST = 16'h0008;
  localparam logic [15:0] A_DV = 16'h000C;

  always #5 clk = ~clk;

  uart_lite #(.AW(16), .TXF_DEPTH(4), .DIV_RST(16'd434)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .uart_req     (req),
    .uart_write   (write),
    .uart_wstrb   (wstrb),
    .uart_addr    (addr),
    .uart_wdata   (wdata),
    .uart_addr_ok (addr_ok),
    .uart_data_ok (data_ok),
    .uart_rdata   (rdata),
    .uart_txd     (txd),
    .uart_rxd     (rxd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
    req = 1'b1; write = wr; addr = a; wdata = wd; wstrb = st;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; write = 1'b0; wstrb = 4'h0;
    rd = rdata;
    chk("data_ok", {31'd0, data_ok}, 32'd1);
  endtask

  task automatic bw(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] dummy;
    xfer(1'b1, a, wd, st, dummy);
  endtask

  task automatic br(input logic [15:0] a, output logic [31:0] rd);
    xfer(1'b0, a, 32'd0, 4'h0, rd);
  endtask

  // Waits (bounded) for a start bit, then samples each bit at its middle.
  task automatic grab_frame(input int per, output logic [7:0] b, output logic ok, output int gap);
    logic start_mid, stop_bit;
    gap = 0; ok = 1'b0; b = 8'd0;
    while (txd !== 1'b0 && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    if (txd === 1'b0) begin
      repeat (per / 2) @(negedge clk);
      start_mid = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (per) @(negedge clk);
        b[i] = txd;
      end
      repeat (per) @(negedge clk);
      stop_bit = txd;
      ok = (start_mid == 1'b0) && (stop_bit == 1'b1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (48) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok;
    int          gap;
    int          lows;
    logic [9:0]  frame;

    rst_b = 1'b0; req = 1'b0; write = 1'b0; wstrb = 4'h0;
    addr = 16'h0; wdata = 32'h0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    br(A_DV, d); chk("rst_div", d, 32'h0000_01B2);
    br(A_ST, d); chk("rst_status", d, 32'h0000_0000);

    // Single frame at DIV=8, 2-cycle start latency
    bw(A_DV, 32'd8, 4'h3);
    br(A_DV, d); chk("div_rdback", d, 32'd8);
    bw(A_TX, 32'hA5, 4'h1);
    @(negedge clk); chk("tx_lat1", {31'd0, txd}, 32'd1);
    @(negedge clk); chk("tx_lat2", {31'd0, txd}, 32'd0);
    frame[0] = txd;
    for (int k = 1; k < 10; k++) begin
      repeat (8) @(negedge clk);
      frame[k] = txd;
    end
    chk("tx_frame_a5", {22'd0, frame}, {22'd0, 1'b1, 8'hA5, 1'b0});
    repeat (8) @(negedge clk);
    br(A_ST, d); chk("tx_done_status", d, 32'h0);

    // Engine busy with 0xFF, then a 5-byte burst: four fit, fifth dropped
    bw(A_TX, 32'hFF, 4'h1);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 5; i++) bw(A_TX, i, 4'h1);
    br(A_ST, d); chk("burst_status", d, 32'h13);
    bw(A_ST, 32'h10, 4'h1);
    br(A_ST, d); chk("drop_cleared", d, 32'h03);
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      grab_frame(8, b, ok, gap);
      chk("b2b_ok", {31'd0, ok}, 32'd1);
      chk("b2b_byte", {24'd0, b}, i);
      if (i > 1) chk("b2b_gap", gap, 32'd4);
    end
    grab_frame(8, b, ok, gap);
    chk("no_fifth", {31'd0, ok}, 32'd0);
    br(A_ST, d); chk("burst_idle", d, 32'h0);

    // DIV below the minimum is clamped to a 4-clock bit
    bw(A_DV, 32'd1, 4'h3);
    br(A_DV, d); chk("div1_rdback", d, 32'd1);
    bw(A_TX, 32'hC3, 4'h1);
    grab_frame(4, b, ok, gap);
    chk("clamp_lat", gap, 32'd2);
    chk("clamp_ok", {31'd0, ok}, 32'd1);
    chk("clamp_byte", {24'd0, b}, 32'hC3);
    repeat (6) @(negedge clk);

    bw(A_DV, 32'd16, 4'h3);
`ifdef UART_RX_EN
    send_rx(8'h3C, 1'b1);
    br(A_RX, d); chk("rx_3c", d, 32'h0000_003C);
    br(A_RX, d); chk("rx_empty", d, 32'h8000_0000);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    br(A_ST, d); chk("rx_ovr_status", d, 32'h04);
    br(A_RX, d); chk("rx_ovr_keep", d, 32'h0000_0011);
    br(A_RX, d); chk("rx_ovr_empty", d, 32'h8000_0000);
    bw(A_ST, 32'h04, 4'h1);
    send_rx(8'h5A, 1'b0);
    br(A_ST, d); chk("rx_ferr_status", d, 32'h08);
    br(A_RX, d); chk("rx_ferr_byte", d, 32'h0000_005A);
    bw(A_ST, 32'h08, 4'h1);
    br(A_ST, d); chk("rx_ferr_clr", d, 32'h0);
`else
    send_rx(8'h3C, 1'b1);
    br(A_RX, d); chk("norx_rxdata", d, 32'h8000_0000);
    br(A_ST, d); chk("norx_status", d, 32'h0);
`endif

    // Asynchronous reset in the middle of a frame
    bw(A_DV, 32'd8, 4'h3);
    bw(A_TX, 32'h00, 4'h1);
    repeat (20) @(negedge clk);
    chk("pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 rst_b = 1'b0;
    #1 chk("async_rst_txd", {31'd0, txd}, 32'd1);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    br(A_ST, d); chk("post_rst_status", d, 32'h0);
    br(A_DV, d); chk("post_rst_div", d, 32'h0000_01B2);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("post_rst_idle", lows, 32'd0);
    bw(A_DV, 32'd16, 4'h3);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    br(A_RX, d); chk("glitch_rxdata", d, 32'h8000_0000);
    br(A_ST, d); chk("glitch_status", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
